mipi_lane_aligner: RTL and testbench

MIPI_LANE_ALIGNER -- requirements
Module: mipi_lane_aligner

---
 rtl/mipi_lane_aligner.sv | 186 ++++++++++++++++++
 tb/tb_mipi_lane_aligner.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mipi_lane_aligner.sv
// MIPI HS lane aligner: per-lane sync hunt, bit-offset alignment and lane deskew.
// Define MIPI_ALIGN_ERR_CNT_EN to add the saturating err_count port.
module mipi_lane_aligner #(
    parameter int unsigned LANES        = 2,
    parameter int unsigned DESKEW_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
    input  logic               mipi_byte_clk,
    input  logic               s_rst,
    input  logic               hs_active,
    input  logic [LANES*8-1:0] lane_byte_data,
    output logic               out_valid,
    output logic [LANES*8-1:0] out_data,
    output logic [LANES-1:0]   lane_locked,
    output logic               sync_err
`ifdef MIPI_ALIGN_ERR_CNT_EN
    ,
    output logic [15:0]        err_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DESKEW_DEPTH);
    localparam int unsigned TMO_W = 4;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DESKEW_DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DESKEW_DEPTH - 2);

    typedef enum logic [1:0] {IDLE, HUNT, STREAM, FAIL} state_e;

    state_e                                    state_q, state_d;
    logic [LANES-1:0][7:0]                     prev_q, prev_d;
    logic [LANES-1:0]                          locked_q, locked_d;
    logic [LANES-1:0][2:0]                     offset_q, offset_d;
    logic [TMO_W-1:0]                          tmo_q, tmo_d;
    logic [LANES-1:0][DESKEW_DEPTH-1:0][7:0]   mem_q, mem_d;
    logic [LANES-1:0][PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                          rd_ptr_q, rd_ptr_d;
    logic                                      out_valid_q, out_valid_d;
    logic [LANES*8-1:0]                        out_data_q, out_data_d;
    logic                                      sync_err_q, sync_err_d;

    logic [LANES-1:0][15:0]                    win;
    logic [LANES-1:0]                          hit;
    logic [LANES-1:0][2:0]                     hit_off;
    logic [LANES-1:0][7:0]                     lane_byte;
    logic                                      wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Sync hunt, FIFO fill/drain and burst control
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        locked_d    = locked_q;
        offset_d    = offset_q;
        tmo_d       = tmo_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        sync_err_d  = 1'b0;
        win         = '0;
        hit         = '0;
        hit_off     = '0;
        lane_byte   = '0;
        wr_en       = (state_q == HUNT) || (state_q == STREAM);

        for (int k = 0; k < LANES; k++) begin
            prev_d[k] = lane_byte_data[8*k +: 8];
            win[k]    = {lane_byte_data[8*k +: 8], prev_q[k]};
            // Descending scan so the lowest matching offset is the one kept
            for (int o = 7; o >= 0; o--) begin
                if (win[k][o +: 8] == SYNC_BYTE) begin
                    hit[k]     = 1'b1;
                    hit_off[k] = 3'(o);
                end
            end
            lane_byte[k] = 8'(win[k] >> offset_q[k]);
            if (wr_en && locked_q[k]) begin
                mem_d[k][wr_ptr_q[k]] = lane_byte[k];
                wr_ptr_d[k]           = ptr_inc(wr_ptr_q[k]);
            end
        end

        case (state_q)
            IDLE: begin
                if (hs_active) state_d = HUNT;
            end
            HUNT: begin
                for (int k = 0; k < LANES; k++) begin
                    if (!locked_q[k] && hit[k]) begin
                        locked_d[k] = 1'b1;
                        offset_d[k] = hit_off[k];
                    end
                end
                if (&locked_q) begin
                    state_d = STREAM;
                end else if (|locked_q) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d    = FAIL;
                        sync_err_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            STREAM: begin
                out_valid_d = 1'b1;
                for (int k = 0; k < LANES; k++) begin
                    out_data_d[8*k +: 8] = mem_q[k][rd_ptr_q];
                end
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: state_d = IDLE;
        endcase

        // Burst end wins over everything and resets the alignment context
        if (!hs_active) begin
            state_d     = IDLE;
            locked_d    = '0;
            offset_d    = '0;
            tmo_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            sync_err_d  = 1'b0;
        end
    end

    always_ff @(posedge mipi_byte_clk) begin
        if (s_rst) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            locked_q    <= '0;
            offset_q    <= '0;
            tmo_q       <= '0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            locked_q    <= locked_d;
            offset_q    <= offset_d;
            tmo_q       <= tmo_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // Valid drops in the very cycle the burst ends
    assign out_valid   = out_valid_q & hs_active;
    assign out_data    = out_data_q;
    assign lane_locked = locked_q;
    assign sync_err    = sync_err_q;

`ifdef MIPI_ALIGN_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sync_err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge mipi_byte_clk) begin
        if (s_rst) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mipi_lane_aligner.sv
// Directed bench for mipi_lane_aligner (LANES=2, DESKEW_DEPTH=4, SYNC_BYTE=B8).
// Byte columns are {lane0, lane1}; expected out_data is {lane1, lane0}.
module tb_mipi_lane_aligner;

    logic        clk = 1'b0;
    logic        s_rst;
    logic        hs_active;
    logic [15:0] lane_byte_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  lane_locked;
    logic        sync_err;
`ifdef MIPI_ALIGN_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    mipi_lane_aligner #(
        .LANES(2),
        .DESKEW_DEPTH(4),
        .SYNC_BYTE(8'hB8)
    ) dut (
        .mipi_byte_clk (clk),
        .s_rst         (s_rst),
        .hs_active     (hs_active),
        .lane_byte_data(lane_byte_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .lane_locked   (lane_locked),
        .sync_err      (sync_err)
`ifdef MIPI_ALIGN_ERR_CNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One byte-clock cycle: drive after the edge, sample at the falling edge
    task automatic vec(input string tag, input logic rst, input logic hs,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic ev, input logic [15:0] ed,
                       input logic [1:0] el, input logic es);
        @(posedge clk);
        #1;
        s_rst          = rst;
        hs_active      = hs;
        lane_byte_data = {b1, b0};
        @(negedge clk);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'(ev));
        if (ev) check_eq({tag, ".data"}, 64'(out_data), 64'(ed));
        check_eq({tag, ".locked"}, 64'(lane_locked), 64'(el));
        check_eq({tag, ".sync_err"}, 64'(sync_err), 64'(es));
    endtask

    initial begin
        s_rst          = 1'b1;
        hs_active      = 1'b0;
        lane_byte_data = '0;

        vec("R0", 1, 0, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("R1", 1, 0, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);
        check_eq("R1.data", 64'(out_data), 64'h0);
`ifdef MIPI_ALIGN_ERR_CNT_EN
        check_eq("R1.err_count", 64'(err_count), 64'h0);
`endif

        // Aligned lanes, sync completes in window at A2, first word at A5
        vec("A0", 0, 1, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("A1", 0, 1, 8'hB8, 8'hB8, 0, 16'h0000, 2'b00, 0);
        vec("A2", 0, 1, 8'h11, 8'h33, 0, 16'h0000, 2'b00, 0);
        vec("A3", 0, 1, 8'h22, 8'h44, 0, 16'h0000, 2'b11, 0);
        vec("A4", 0, 1, 8'h55, 8'h66, 0, 16'h0000, 2'b11, 0);
        vec("A5", 0, 1, 8'h77, 8'h88, 1, 16'h3311, 2'b11, 0);
        vec("A6", 0, 1, 8'h99, 8'hAA, 1, 16'h4422, 2'b11, 0);
        vec("A7", 0, 0, 8'hBB, 8'hCC, 0, 16'h0000, 2'b11, 0);
        vec("A8", 0, 0, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);

        // Lane0 carries B8,5A,C3,A5 delayed by 3 bits; lane1 is byte aligned
        vec("B0", 0, 1, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("B1", 0, 1, 8'hC0, 8'hB8, 0, 16'h0000, 2'b00, 0);
        vec("B2", 0, 1, 8'hD5, 8'h77, 0, 16'h0000, 2'b00, 0);
        vec("B3", 0, 1, 8'h1A, 8'h88, 0, 16'h0000, 2'b11, 0);
        check_eq("B3.off0", 64'(dut.offset_q[0]), 64'd3);
        check_eq("B3.off1", 64'(dut.offset_q[1]), 64'd0);
        vec("B4", 0, 1, 8'h2E, 8'h99, 0, 16'h0000, 2'b11, 0);
        vec("B5", 0, 1, 8'h05, 8'hAA, 1, 16'h775A, 2'b11, 0);
        vec("B6", 0, 1, 8'h00, 8'hBB, 1, 16'h88C3, 2'b11, 0);
        vec("B7", 0, 0, 8'h00, 8'h00, 0, 16'h0000, 2'b11, 0);

        // Lane1 sync two cycles behind lane0: deskewed, no error
        vec("C0", 0, 1, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("C1", 0, 1, 8'hB8, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("C2", 0, 1, 8'hA1, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("C3", 0, 1, 8'hA2, 8'hB8, 0, 16'h0000, 2'b01, 0);
        vec("C4", 0, 1, 8'hA3, 8'hB1, 0, 16'h0000, 2'b01, 0);
        vec("C5", 0, 1, 8'hA4, 8'hB2, 0, 16'h0000, 2'b11, 0);
        vec("C6", 0, 1, 8'hA5, 8'hB3, 0, 16'h0000, 2'b11, 0);
        vec("C7", 0, 1, 8'hA6, 8'hB4, 1, 16'hB1A1, 2'b11, 0);
        vec("C8", 0, 1, 8'hA7, 8'hB5, 1, 16'hB2A2, 2'b11, 0);
        vec("C9", 0, 0, 8'h00, 8'h00, 0, 16'h0000, 2'b11, 0);

        // Lane1 never syncs: sync_err three cycles after lane0 shows locked
        vec("D0", 0, 1, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("D1", 0, 1, 8'hB8, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("D2", 0, 1, 8'h01, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("D3", 0, 1, 8'h02, 8'h00, 0, 16'h0000, 2'b01, 0);
        vec("D4", 0, 1, 8'h03, 8'h00, 0, 16'h0000, 2'b01, 0);
        vec("D5", 0, 1, 8'h04, 8'h00, 0, 16'h0000, 2'b01, 0);
        vec("D6", 0, 1, 8'h05, 8'h00, 0, 16'h0000, 2'b01, 1);
`ifdef MIPI_ALIGN_ERR_CNT_EN
        check_eq("D6.err_count", 64'(err_count), 64'd1);
`endif
        vec("D7", 0, 1, 8'h06, 8'h00, 0, 16'h0000, 2'b01, 0);
        vec("D8", 0, 0, 8'h00, 8'h00, 0, 16'h0000, 2'b01, 0);

        // Reset in STREAM with hs_active still high
        vec("E0", 0, 1, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);
`ifdef MIPI_ALIGN_ERR_CNT_EN
        check_eq("E0.err_count", 64'(err_count), 64'd1);
`endif
        vec("E1", 0, 1, 8'hB8, 8'hB8, 0, 16'h0000, 2'b00, 0);
        vec("E2", 0, 1, 8'h11, 8'h33, 0, 16'h0000, 2'b00, 0);
        vec("E3", 0, 1, 8'h22, 8'h44, 0, 16'h0000, 2'b11, 0);
        vec("E4", 0, 1, 8'h55, 8'h66, 0, 16'h0000, 2'b11, 0);
        vec("E5", 0, 1, 8'h77, 8'h88, 1, 16'h3311, 2'b11, 0);
        vec("E6", 1, 1, 8'h99, 8'hAA, 1, 16'h4422, 2'b11, 0);
        vec("E7", 0, 1, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);
        check_eq("E7.data", 64'(out_data), 64'h0);
`ifdef MIPI_ALIGN_ERR_CNT_EN
        check_eq("E7.err_count", 64'(err_count), 64'h0);
`endif

        // Burst ends during HUNT with no lock: quiet return to IDLE
        vec("F0", 0, 1, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("F1", 0, 0, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);
        vec("F2", 0, 0, 8'h00, 8'h00, 0, 16'h0000, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
